// File: rtl/regfile_sequencer.sv
// Sequences one ALU operation over an external register file: read src, read dst, write dst, respond.
// Optional build macro REGFILE_SEQ_SAME_REG_EN: when src==dst, the second read is skipped (B=A).
module regfile_sequencer #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        req_op,
    input  logic [ADDR_W-1:0] req_dst,
    input  logic [ADDR_W-1:0] req_src,
    output logic [ADDR_W-1:0] rf_addr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              rf_we,
    input  logic [DATA_W-1:0] rf_rdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_result,
    output logic [1:0]        rsp_flags
);

    typedef enum logic [2:0] {IDLE, RD_SRC, RD_DST, WR, RSP} state_e;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_MOV = 3'd5;
    localparam logic [2:0] OP_NOT = 3'd6;
    localparam logic [2:0] OP_CMP = 3'd7;

    state_e            state_q, state_d;
    logic [2:0]        op_q, op_d;
    logic [ADDR_W-1:0] dst_q, dst_d;
    logic [ADDR_W-1:0] src_q, src_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic [1:0]        flags_q, flags_d;
    logic [DATA_W+1:0] alu_out;
    logic              single_op;
    logic              skip_dst;

    // Returns {C, Z, result}; B is the destination operand, A the source operand.
    function automatic logic [DATA_W+1:0] alu(input logic [2:0] op,
                                              input logic [DATA_W-1:0] a,
                                              input logic [DATA_W-1:0] b);
        logic [DATA_W:0]   wide;
        logic [DATA_W-1:0] res;
        logic              c;
        wide = '0;
        res  = '0;
        c    = 1'b0;
        case (op)
            OP_ADD: begin
                wide = {1'b0, b} + {1'b0, a};
                res  = wide[DATA_W-1:0];
                c    = wide[DATA_W];
            end
            OP_SUB, OP_CMP: begin
                wide = {1'b0, b} - {1'b0, a};
                res  = wide[DATA_W-1:0];
                c    = wide[DATA_W];
            end
            OP_AND:  res = b & a;
            OP_OR:   res = b | a;
            OP_XOR:  res = b ^ a;
            OP_MOV:  res = a;
            OP_NOT:  res = ~a;
            default: res = '0;
        endcase
        return {c, (res == '0), res};
    endfunction

    assign single_op = (op_q == OP_MOV) || (op_q == OP_NOT);
`ifdef REGFILE_SEQ_SAME_REG_EN
    assign skip_dst = !single_op && (src_q == dst_q);
`else
    assign skip_dst = 1'b0;
`endif

    // NOTE: synchronous reset -- the branch is evaluated only on the clock edge, never asynchronously.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            op_q     <= '0;
            dst_q    <= '0;
            src_q    <= '0;
            a_q      <= '0;
            result_q <= '0;
            flags_q  <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            dst_q    <= dst_d;
            src_q    <= src_d;
            a_q      <= a_d;
            result_q <= result_d;
            flags_q  <= flags_d;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        dst_d     = dst_q;
        src_d     = src_q;
        a_d       = a_q;
        result_d  = result_q;
        flags_d   = flags_q;
        alu_out   = '0;
        req_ready = 1'b0;
        rf_addr   = '0;
        rf_wdata  = '0;
        rf_we     = 1'b0;
        rsp_valid = 1'b0;

        case (state_q)
            IDLE: begin
                req_ready = rst_n;
                if (req_valid && rst_n) begin
                    op_d    = req_op;
                    dst_d   = req_dst;
                    src_d   = req_src;
                    state_d = RD_SRC;
                end
            end
            RD_SRC: begin
                rf_addr = src_q;
                a_d     = rf_rdata;
                if (single_op || skip_dst) begin
                    alu_out  = alu(op_q, rf_rdata, rf_rdata);
                    result_d = alu_out[DATA_W-1:0];
                    flags_d  = alu_out[DATA_W+1:DATA_W];
                    state_d  = (op_q == OP_CMP) ? RSP : WR;
                end else begin
                    state_d = RD_DST;
                end
            end
            RD_DST: begin
                rf_addr  = dst_q;
                alu_out  = alu(op_q, a_q, rf_rdata);
                result_d = alu_out[DATA_W-1:0];
                flags_d  = alu_out[DATA_W+1:DATA_W];
                state_d  = (op_q == OP_CMP) ? RSP : WR;
            end
            WR: begin
                rf_addr  = dst_q;
                rf_wdata = result_q;
                rf_we    = rst_n;  // a write colliding with reset is dropped
                state_d  = RSP;
            end
            RSP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign rsp_result = result_q;
    assign rsp_flags  = flags_q;

endmodule

// File: tb/tb_regfile_sequencer.sv
// Directed bench for regfile_sequencer with a behavioural register file and a result scoreboard.
// Define REGFILE_SEQ_SAME_REG_EN for both RTL and bench to cover the same-register shortcut.
module tb_regfile_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req_valid;
    logic       req_ready;
    logic [2:0] req_op;
    logic [3:0] req_dst;
    logic [3:0] req_src;
    logic [3:0] rf_addr;
    logic [7:0] rf_wdata;
    logic       rf_we;
    logic [7:0] rf_rdata;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_result;
    logic [1:0] rsp_flags;

    always #5 clk = ~clk;

    regfile_sequencer #(.ADDR_W(4), .DATA_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_dst    (req_dst),
        .req_src    (req_src),
        .rf_addr    (rf_addr),
        .rf_wdata   (rf_wdata),
        .rf_we      (rf_we),
        .rf_rdata   (rf_rdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_flags  (rsp_flags)
    );

    // Register file driven by the DUT, and an independent model of what it should hold.
    logic [7:0] rf  [16];
    logic [7:0] mdl [16];
    logic       rf_init;
    int         we_cnt = 0;
    logic [3:0] we_addr = '0;
    logic [7:0] we_data = '0;
    int         idle_wdata_bad = 0;

    assign rf_rdata = rf[rf_addr];

    always @(posedge clk) begin
        if (rf_init) begin
            for (int i = 0; i < 16; i++) rf[i] <= 8'(i);
        end else if (rf_we) begin
            rf[rf_addr] <= rf_wdata;
            we_cnt      <= we_cnt + 1;
            we_addr     <= rf_addr;
            we_data     <= rf_wdata;
        end
    end

    always @(negedge clk) begin
        if (rst_n && !rf_we && rf_wdata !== 8'h00) idle_wdata_bad <= idle_wdata_bad + 1;
    end

    typedef struct {
        logic [7:0] result;
        logic [1:0] flags;
        logic       wr;
    } exp_t;

    exp_t sb[$];
    int   n_pass  = 0;
    int   n_total = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Reference ALU: returns {C, Z, result}, B = dst operand, A = src operand.
    function automatic logic [9:0] model(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        logic [8:0] wide;
        logic [7:0] r;
        logic       c;
        r = 8'h00;
        c = 1'b0;
        case (op)
            3'd0: begin wide = {1'b0, b} + {1'b0, a}; r = wide[7:0]; c = wide[8]; end
            3'd1, 3'd7: begin r = b - a; c = (b < a); end
            3'd2: r = b & a;
            3'd3: r = b | a;
            3'd4: r = b ^ a;
            3'd5: r = a;
            3'd6: r = ~a;
            default: r = 8'h00;
        endcase
        return {c, (r == 8'h00), r};
    endfunction

    // Entered and left at a negedge, so a follow-on call re-requests one cycle after the handshake.
    task automatic run_op(input logic [2:0] op, input logic [3:0] dst, input logic [3:0] src,
                          input int hold, input bit keep_valid);
        exp_t       e;
        exp_t       got;
        logic [9:0] m;
        int         lat;
        int         exp_lat;
        int         we0;
        bit         ready_busy;

        m        = model(op, mdl[src], mdl[dst]);
        e.result = m[7:0];
        e.flags  = m[9:8];
        e.wr     = (op != 3'd7);
        if (e.wr) mdl[dst] = e.result;
        exp_lat = (op == 3'd5 || op == 3'd6 || op == 3'd7) ? 3 : 4;
`ifdef REGFILE_SEQ_SAME_REG_EN
        if (src == dst && op != 3'd5 && op != 3'd6) exp_lat--;
`endif
        sb.push_back(e);

        req_op    = op;
        req_dst   = dst;
        req_src   = src;
        req_valid = 1'b1;
        we0       = we_cnt;
        check("req_ready_idle", req_ready, 1);
        @(posedge clk);
        @(negedge clk);
        if (!keep_valid) req_valid = 1'b0;

        lat        = 1;
        ready_busy = 1'b0;
        while (!rsp_valid && lat < 20) begin
            ready_busy |= req_ready;
            @(negedge clk);
            lat++;
        end
        check("latency", lat, exp_lat);
        check("ready_while_busy", ready_busy, 0);

        got = sb.pop_front();
        check("rsp_result", rsp_result, got.result);
        check("rsp_flags", rsp_flags, got.flags);

        for (int h = 0; h < hold; h++) begin
            check("hold_result", rsp_result, got.result);
            check("hold_flags", rsp_flags, got.flags);
            check("hold_ready", req_ready, 0);
            check("hold_valid", rsp_valid, 1);
            check("hold_rf_addr", rf_addr, 0);
            @(negedge clk);
        end

        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        req_valid = 1'b0;
        check("rsp_valid_after_hs", rsp_valid, 0);
        check("ready_after_hs", req_ready, 1);
        check("write_count", we_cnt - we0, got.wr ? 1 : 0);
        if (got.wr) begin
            check("write_addr", we_addr, dst);
            check("write_data", we_data, got.result);
        end
        check("rf_dst", rf[dst], mdl[dst]);
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_op    = '0;
        req_dst   = '0;
        req_src   = '0;
        rsp_ready = 1'b0;
        rf_init   = 1'b1;
        for (int i = 0; i < 16; i++) mdl[i] = 8'(i);

        @(negedge clk);
        @(negedge clk);
        rf_init = 1'b0;
        check("rst_req_ready", req_ready, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_result", rsp_result, 0);
        check("rst_rsp_flags", rsp_flags, 0);
        check("rst_rf_we", rf_we, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_out_of_rst", req_ready, 1);

        // ADD r3,r5 aborted by reset during the WR cycle: no write, no response.
        req_op    = 3'd0;
        req_dst   = 4'd3;
        req_src   = 4'd5;
        req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("abort_wr_we", rf_we, 1);
        check("abort_wr_addr", rf_addr, 3);
        check("abort_wr_data", rf_wdata, 8);
        rst_n = 1'b0;
        #1;
        check("abort_we_gated", rf_we, 0);
        check("abort_ready_in_rst", req_ready, 0);
        @(negedge clk);
        rst_n = 1'b1;
        check("abort_rsp_valid_a", rsp_valid, 0);
        @(negedge clk);
        check("abort_rsp_valid_b", rsp_valid, 0);
        check("abort_ready", req_ready, 1);
        check("abort_r3", rf[3], 3);
        check("abort_no_write", we_cnt, 0);

        run_op(3'd0, 4'd3,  4'd5,  0, 1'b0);  // ADD  r3 = 3+5
        run_op(3'd1, 4'd2,  4'd5,  0, 1'b0);  // SUB  r2 = 2-5 wraps, borrow
        run_op(3'd7, 4'd7,  4'd7,  0, 1'b0);  // CMP  r7,r7 -> Z only
        run_op(3'd2, 4'd3,  4'd2,  3, 1'b1);  // AND  with stalled consumer and held request
        run_op(3'd3, 4'd1,  4'd6,  0, 1'b0);  // OR   accepted right after the handshake
        run_op(3'd4, 4'd0,  4'd1,  1, 1'b0);  // XOR
        run_op(3'd5, 4'd9,  4'd3,  0, 1'b0);  // MOV
        run_op(3'd6, 4'd10, 4'd0,  0, 1'b0);  // NOT
        run_op(3'd0, 4'd4,  4'd4,  0, 1'b0);  // ADD  r4 = r4+r4
        run_op(3'd0, 4'd2,  4'd10, 0, 1'b0);  // ADD  with carry-out
        run_op(3'd1, 4'd11, 4'd11, 0, 1'b0);  // SUB  same register -> zero

        check("wdata_zero_outside_wr", idle_wdata_bad, 0);
        check("scoreboard_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish, observed=timeout expected=finish");
        $fatal(1);
    end

endmodule
